vga_frame_reader: RTL
=====================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_VIS, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_VIS, default 480: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 Clock  input  1  system clock (50 MHz); single clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 oReadAddress  output  19  video-memory read address, linear row*H_VIS+col.
REQ-008 iPixelData  input  3  {R,G,B} from video memory, valid exactly 1 Clock after oReadAddress changes.
REQ-009 oRed, oGreen, oBlue  output  1 each  pixel colour to the DAC pins.
REQ-010 oHsync, oVsync  output  1 each  sync outputs, active-low.
REQ-011 oFrameStart  output  1  one-Clock pulse at the first pixel tick of each frame.

Function
REQ-012 A phase bit toggles every Clock; the pixel tick is asserted when phase=1 (25 MHz pixel rate, 2 Clocks per pixel).
REQ-013 Horizontal counter hCount (10 b) increments on each pixel tick, range 0..H_TOTAL-1 (H_TOTAL=800), and wraps to 0.
REQ-014 Vertical counter vCount (10 b) increments on a pixel tick when hCount=H_TOTAL-1, range 0..V_TOTAL-1 (V_TOTAL=525), and wraps to 0.
REQ-015 Visible region: hCount<H_VIS and vCount<V_VIS.
REQ-016 oReadAddress is generated by an incrementing register, with no multiplier.
REQ-017 oReadAddress holds the address of the current (hCount,vCount) while visible, increments by 1 on each visible pixel tick, and holds during blanking.
REQ-018 oReadAddress returns to 0 on the tick that wraps hCount=799,vCount=524 to 0,0.
REQ-019 iPixelData is sampled on the pixel tick following the address change, which is 2 Clocks later and satisfies the 1-Clock RAM latency.
REQ-020 Output stage is registered and updates only on pixel ticks.
REQ-021 oRed/oGreen/oBlue and the syncs lag the counters by exactly 1 pixel tick, so colour and sync stay aligned.
REQ-022 The colour outputs equal sampled iPixelData when the delayed visible flag is 1, else 0.
REQ-023 oHsync=0 iff the delayed hCount is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751].
REQ-024 oVsync=0 iff the delayed vCount is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490,491].
REQ-025 oFrameStart=1 for exactly 1 Clock, on the Clock where the delayed (h,v)=(0,0) is first presented.
REQ-026 The block has no stall or back-pressure input; timing is free-running and unaffected by iPixelData value or writes to video memory.
REQ-027 Concurrent writes to video memory are not arbitrated here; a write to the address being read may show old or new data for that one pixel only.

Reset
REQ-028 While Reset=1, on every Clock: phase=0, hCount=0, vCount=0, oReadAddress=0, oRed=oGreen=oBlue=0, oHsync=1, oVsync=1, oFrameStart=0.
REQ-029 Reset asserted mid-frame abandons the frame immediately, with no completion of the current line.
REQ-030 After Reset deasserts, the first pixel tick occurs on the 2nd Clock and the frame restarts at (0,0), address 0.

Verification
REQ-031 Reset, then run 1 frame -> hsync period 1600 Clocks, hsync low width 192 Clocks, vsync period 840000 Clocks, vsync low width 3200 Clocks.
REQ-032 Model RAM returning iPixelData=address[2:0] -> first visible pixel of line 1 shows {R,G,B}=640[2:0]=3'b000, pixel col 5 of line 0 shows 3'b101, and oReadAddress at line 1 col 0 is 640.
REQ-033 Tie iPixelData=3'b111 -> RGB=0 for delayed hCount 640..799 and vCount 480..524, RGB=111 elsewhere; no RGB during oHsync=0.
REQ-034 Run to the end of the frame -> oReadAddress reaches 307199 at (639,479), holds through blanking, returns to 0 at frame wrap, and oFrameStart pulses once per 840000 Clocks.
REQ-035 Assert Reset for 3 Clocks at line 200 col 300 -> all outputs take reset values on the next Clock, and after release timing restarts at (0,0) with the first hsync low starting exactly 1314 Clocks later.
REQ-036 Randomise iPixelData every Clock -> each output colour equals the iPixelData sampled 2 Clocks after its address was issued (scoreboard check, no off-by-one).

Source files
------------

// File: rtl/vga_frame_reader.sv
// VGA frame reader: free-running 640x480 timing at half the system clock, linear
// video-memory address generation and a one-tick registered output stage.
module vga_frame_reader #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [18:0] oReadAddress,
    input  logic [2:0]  iPixelData,
    output logic        oRed,
    output logic        oGreen,
    output logic        oBlue,
    output logic        oHsync,
    output logic        oVsync,
    output logic        oFrameStart
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    logic        r_phase;
    logic [9:0]  r_hcount_p0;
    logic [9:0]  r_vcount_p0;
    logic [18:0] r_addr_p0;

    logic [2:0]  r_rgb_p1;
    logic        r_hsync_p1;
    logic        r_vsync_p1;
    logic        r_frame_start_p1;

    logic        w_vld_p0;
    logic        w_hwrap;
    logic        w_vwrap;
    logic [9:0]  w_hnext;
    logic [9:0]  w_vnext;
    logic        w_vis_p0;
    logic        w_vis_next;
    logic        w_hsync_act;
    logic        w_vsync_act;
    logic        w_origin;

    always_comb begin
        w_vld_p0    = r_phase;
        w_hwrap     = (r_hcount_p0 == H_LAST);
        w_vwrap     = (r_vcount_p0 == V_LAST);
        w_hnext     = w_hwrap ? 10'd0 : r_hcount_p0 + 10'd1;
        w_vnext     = r_vcount_p0;
        if (w_hwrap) begin
            w_vnext = w_vwrap ? 10'd0 : r_vcount_p0 + 10'd1;
        end
        w_vis_p0    = (r_hcount_p0 < H_VIS_C) && (r_vcount_p0 < V_VIS_C);
        w_vis_next  = (w_hnext < H_VIS_C) && (w_vnext < V_VIS_C);
        w_hsync_act = in_window(r_hcount_p0, HS_BEG, HS_END);
        w_vsync_act = in_window(r_vcount_p0, VS_BEG, VS_END);
        w_origin    = (r_hcount_p0 == 10'd0) && (r_vcount_p0 == 10'd0);
    end

    // Stage p0: pixel tick, raster counters and read address
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_phase     <= 1'b0;
            r_hcount_p0 <= '0;
            r_vcount_p0 <= '0;
            r_addr_p0   <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (w_vld_p0) begin
                r_hcount_p0 <= w_hnext;
                r_vcount_p0 <= w_vnext;
                // The address steps as the raster enters each visible pixel, so across
                // blanking it parks on the last pixel shown and lines chain without a multiply.
                if (w_hwrap && w_vwrap) begin
                    r_addr_p0 <= '0;
                end else if (w_vis_next) begin
                    r_addr_p0 <= r_addr_p0 + 19'd1;
                end
            end
        end
    end

    // Stage p1: colour and sync registered together, one tick behind the counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rgb_p1         <= 3'b000;
            r_hsync_p1       <= 1'b1;
            r_vsync_p1       <= 1'b1;
            r_frame_start_p1 <= 1'b0;
        end else begin
            r_frame_start_p1 <= w_vld_p0 && w_origin;
            if (w_vld_p0) begin
                r_rgb_p1   <= w_vis_p0 ? iPixelData : 3'b000;
                r_hsync_p1 <= ~w_hsync_act;
                r_vsync_p1 <= ~w_vsync_act;
            end
        end
    end

    assign oReadAddress = r_addr_p0;
    assign oRed         = r_rgb_p1[2];
    assign oGreen       = r_rgb_p1[1];
    assign oBlue        = r_rgb_p1[0];
    assign oHsync       = r_hsync_p1;
    assign oVsync       = r_vsync_p1;
    assign oFrameStart  = r_frame_start_p1;

endmodule
